// File: rtl/uart_tx_if.sv
// Register-bus signals between the iosystem byte-lane decode and the UART transmitter.
interface uart_tx_if;
    logic [7:0]  data_in;
    logic        data_write;
    logic        status_write;
    logic [15:0] divisor_in;
    logic [1:0]  divisor_write;
    logic [15:0] divisor_out;
    logic [7:0]  status_out;

    modport master (
        output data_in, data_write, status_write, divisor_in, divisor_write,
        input  divisor_out, status_out
    );

    modport slave (
        input  data_in, data_write, status_write, divisor_in, divisor_write,
        output divisor_out, status_out
    );
endinterface

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO, programmable bit period,
// sticky overflow flag and a drained-transmitter level interrupt.
module uart_tx #(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter logic [15:0] RESET_DIVISOR = 16'd9
) (
    input  logic     clk,
    input  logic     reset,
    uart_tx_if.slave bus,
    output logic     tx,
    output logic     empty_int
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e             state_q, state_d;
    logic [15:0]        bcnt_q, bcnt_d;
    logic [15:0]        div_q, div_d;
    logic [2:0]         bidx_q, bidx_d;
    logic [7:0]         sh_q, sh_d;
    logic               tx_q, tx_d;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               empty_q, empty_d, full_q, full_d;
    logic               ovf_q, ovf_d, busy_q, busy_d, eint_q, eint_d;
    logic               push, pop;

    // Frame sequencer; a pop loads the shift register and restarts the bit period.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        bidx_d  = bidx_q;
        sh_d    = sh_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_q) begin
                    pop     = 1'b1;
                    sh_d    = mem_q[rptr_q];
                    bcnt_d  = div_q;
                    state_d = START;
                end
            end
            START: begin
                if (bcnt_q == 16'd0) begin
                    bidx_d  = 3'd0;
                    bcnt_d  = div_q;
                    state_d = DATA;
                end else begin
                    bcnt_d = bcnt_q - 16'd1;
                end
            end
            DATA: begin
                if (bcnt_q == 16'd0) begin
                    sh_d   = {1'b0, sh_q[7:1]};
                    bcnt_d = div_q;
                    if (bidx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bidx_d = bidx_q + 3'd1;
                    end
                end else begin
                    bcnt_d = bcnt_q - 16'd1;
                end
            end
            STOP: begin
                if (bcnt_q == 16'd0) begin
                    if (!empty_q) begin
                        pop     = 1'b1;
                        sh_d    = mem_q[rptr_q];
                        bcnt_d  = div_q;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    bcnt_d = bcnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level mirrors the current state, landing one edge later.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = sh_q[0];
            default: tx_d = 1'b1;
        endcase
    end

    // FIFO bookkeeping, overflow flag, divisor lanes and status flags.
    always_comb begin
        push   = bus.data_write && !full_q;
        wptr_d = push ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d = pop  ? rptr_q + PTR_W'(1) : rptr_q;
        cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop);

        empty_d = (cnt_d == CNT_W'(0));
        full_d  = (cnt_d == CNT_W'(FIFO_DEPTH));

        ovf_d = ovf_q;
        if (bus.status_write && bus.data_in[2]) begin
            ovf_d = 1'b0;
        end
        if (bus.data_write && full_q) begin
            ovf_d = 1'b1;
        end

        div_d = div_q;
        if (bus.divisor_write[0]) begin
            div_d[7:0] = bus.divisor_in[7:0];
        end
        if (bus.divisor_write[1]) begin
            div_d[15:8] = bus.divisor_in[15:8];
        end

        busy_d = (state_d != IDLE);
        eint_d = empty_d && !busy_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bcnt_q  <= 16'd0;
            bidx_q  <= 3'd0;
            sh_q    <= 8'd0;
            tx_q    <= 1'b1;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            eint_q  <= 1'b1;
            div_q   <= RESET_DIVISOR;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            bidx_q  <= bidx_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            eint_q  <= eint_d;
            div_q   <= div_d;
        end
    end

    // Storage needs no reset: the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= bus.data_in;
        end
    end

    assign tx              = tx_q;
    assign empty_int       = eint_q;
    assign bus.divisor_out = div_q;
    assign bus.status_out  = {4'b0000, busy_q, ovf_q, full_q, empty_q};

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-level reference model checked every cycle,
// plus directed scenarios with hand-computed waveforms.
module tb_uart_tx;
    localparam int unsigned DEPTH = 4;
    localparam logic [15:0] RDIV  = 16'd9;

    logic clk;
    logic reset;
    logic tx;
    logic eint;

    uart_tx_if bus();

    uart_tx #(.FIFO_DEPTH(DEPTH), .RESET_DIVISOR(RDIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .tx        (tx),
        .empty_int (eint)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: a queue of pending bytes and the 10-bit frame on the line,
    // walked one bit period (divisor+1 clocks) at a time.
    logic [7:0]  mq[$];
    logic        m_ovf  = 1'b0;
    logic [15:0] m_div  = RDIV;
    bit          m_act  = 1'b0;
    logic [9:0]  m_frame = 10'h3FF;
    int          m_bit  = 0;
    int          m_left = 0;
    logic        m_tx   = 1'b1;

    task automatic load_frame(input logic [15:0] d);
        logic [7:0] b;
        b       = mq.pop_front();
        m_frame = {1'b1, b, 1'b0};
        m_bit   = 0;
        m_left  = int'(d);
        m_act   = 1'b1;
    endtask

    always @(posedge clk) begin : model_p
        logic [15:0] dpre;
        bit          fpre;
        logic        txn;
        if (reset) begin
            mq.delete();
            m_ovf = 1'b0;
            m_div = RDIV;
            m_act = 1'b0;
            m_tx  = 1'b1;
        end else begin
            dpre = m_div;
            fpre = (mq.size() == DEPTH);
            txn  = m_act ? m_frame[m_bit] : 1'b1;
            if (!m_act) begin
                if (mq.size() > 0) load_frame(dpre);
            end else if (m_left > 0) begin
                m_left--;
            end else if (m_bit < 9) begin
                m_bit++;
                m_left = int'(dpre);
            end else if (mq.size() > 0) begin
                load_frame(dpre);
            end else begin
                m_act = 1'b0;
            end
            if (bus.data_write && !fpre) mq.push_back(bus.data_in);
            if (bus.status_write && bus.data_in[2]) m_ovf = 1'b0;
            if (bus.data_write && fpre) m_ovf = 1'b1;
            if (bus.divisor_write[0]) m_div[7:0]  = bus.divisor_in[7:0];
            if (bus.divisor_write[1]) m_div[15:8] = bus.divisor_in[15:8];
            m_tx = txn;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("tx", 32'(tx), 32'(m_tx));
            check("empty_int", 32'(eint), 32'(mq.size() == 0 && !m_act));
            check("status", 32'(bus.status_out),
                  32'({4'b0000, m_act, m_ovf, mq.size() == DEPTH, mq.size() == 0}));
            check("divisor", 32'(bus.divisor_out), 32'(m_div));
        end
    end

    task automatic idle_in();
        bus.data_write    = 1'b0;
        bus.status_write  = 1'b0;
        bus.divisor_write = 2'b00;
    endtask

    task automatic set_div(input logic [15:0] d);
        bus.divisor_in    = d;
        bus.divisor_write = 2'b11;
        @(negedge clk);
        bus.divisor_write = 2'b00;
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (eint === 1'b1 && bus.status_out[3] === 1'b0) done = 1'b1;
        end
        check(name, 32'(done), 32'd1);
    endtask

    initial begin
        logic [39:0] v40, e40;
        logic [9:0]  v10;
        bit          any_low;
        bit          fbits [10];

        bus.data_in    = 8'h00;
        bus.divisor_in = 16'h0000;
        idle_in();
        reset = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_status", 32'(bus.status_out), 32'h01);
        check("rst_divisor", 32'(bus.divisor_out), 32'h0009);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_int", 32'(eint), 32'd1);

        // Divisor byte lanes
        bus.divisor_in = 16'h1234; bus.divisor_write = 2'b01;
        @(negedge clk);
        bus.divisor_write = 2'b00;
        check("div_lane0", 32'(bus.divisor_out), 32'h0034);
        bus.divisor_in = 16'hAB00; bus.divisor_write = 2'b10;
        @(negedge clk);
        bus.divisor_write = 2'b00;
        check("div_lane1", 32'(bus.divisor_out), 32'hAB34);
        set_div(16'd3);

        // 8'hA5 at divisor 3: start, 1,0,1,0,0,1,0,1, stop -- 4 clocks each
        fbits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int j = 0; j < 40; j++) e40[j] = fbits[j / 4];
        bus.data_in = 8'hA5; bus.data_write = 1'b1;
        @(negedge clk);
        bus.data_write = 1'b0;
        @(negedge clk);
        check("a5_pre_start", 32'(tx), 32'd1);
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            v40[j] = tx;
            if (j == 38) check("a5_int_busy", 32'(eint), 32'd0);
        end
        check("a5_frame", 32'(v40), 32'(e40));
        check("a5_int_end", 32'(eint), 32'd1);

        // Divisor changed mid-frame
        bus.data_in = 8'h3C; bus.data_write = 1'b1;
        @(negedge clk);
        bus.data_write = 1'b0;
        repeat (10) @(negedge clk);
        set_div(16'd1);
        drain("midframe_drain");

        // Five writes fit (first pop frees a slot), sixth is dropped
        for (int i = 0; i < 5; i++) begin
            bus.data_in = 8'(i + 1); bus.data_write = 1'b1;
            @(negedge clk);
        end
        bus.data_in = 8'h06;
        @(negedge clk);
        bus.data_write = 1'b0;
        check("ovf_set", 32'(bus.status_out), 32'h0E);
        bus.data_in = 8'h04; bus.status_write = 1'b1;
        @(negedge clk);
        bus.status_write = 1'b0;
        check("ovf_clear", 32'(bus.status_out), 32'h0A);
        bus.data_write = 1'b1; bus.status_write = 1'b1;
        @(negedge clk);
        idle_in();
        check("ovf_set_wins", 32'(bus.status_out), 32'h0E);
        bus.status_write = 1'b1;
        @(negedge clk);
        bus.status_write = 1'b0;
        drain("burst_drain");

        // Reset during data bit 4 discards the frame and the queued byte
        set_div(16'd3);
        bus.data_in = 8'h5A; bus.data_write = 1'b1;
        @(negedge clk);
        bus.data_in = 8'h77;
        @(negedge clk);
        bus.data_write = 1'b0;
        repeat (21) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_tx", 32'(tx), 32'd1);
        check("rst_mid_status", 32'(bus.status_out), 32'h01);
        check("rst_mid_int", 32'(eint), 32'd1);
        any_low = 1'b0;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            if (tx !== 1'b1) any_low = 1'b1;
        end
        check("rst_no_residual", 32'(any_low), 32'd0);

        // Divisor 0: one clock per bit
        set_div(16'd0);
        bus.data_in = 8'hFF; bus.data_write = 1'b1;
        @(negedge clk);
        bus.data_write = 1'b0;
        @(negedge clk);
        check("ff_pre_start", 32'(tx), 32'd1);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            v10[j] = tx;
        end
        check("ff_frame", 32'(v10), 32'h3FE);
        check("ff_int_end", 32'(eint), 32'd1);

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            bus.data_in       = 8'($urandom);
            bus.data_write    = ($urandom_range(0, 2) == 0);
            bus.status_write  = ($urandom_range(0, 7) == 0);
            bus.divisor_in    = {8'h00, 8'($urandom_range(0, 3))};
            bus.divisor_write = ($urandom_range(0, 49) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            reset             = ($urandom_range(0, 699) == 0);
            @(negedge clk);
        end
        idle_in();
        reset = 1'b0;
        drain("final_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
